// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    localparam int MDU_ITER = 32;

    localparam logic [31:0] MDU_DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: shift-add multiply or restoring divide.
module mdu_step (
    input  logic        is_div_i,
    input  logic [63:0] acc_i,
    input  logic [31:0] opb_i,
    output logic [63:0] acc_o
);

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {remainder, dividend bits shifting out / quotient bits shifting in}.
    logic [32:0] sum;
    logic [32:0] part;
    logic [32:0] trial;

    always_comb begin
        sum   = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opb_i} : 33'd0);
        part  = {acc_i[63:32], acc_i[31]};
        trial = part - {1'b0, opb_i};
        if (is_div_i) begin
            // Borrow means the trial subtract failed: keep the shifted remainder.
            if (trial[32]) acc_o = {part[31:0], acc_i[30:0], 1'b0};
            else           acc_o = {trial[31:0], acc_i[30:0], 1'b1};
        end else begin
            acc_o = {sum, acc_i[31:1]};
        end
    end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with the architectural HI/LO registers.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int ITER = MDU_ITER
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = $clog2(ITER);

    mdu_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opb_q, opb_d;
    logic        is_div_q, is_div_d;
    logic        sgn_a_q, sgn_a_d;
    logic        neg_q, neg_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        a_neg, b_neg;
    logic [31:0] a_abs, b_abs;
    logic [63:0] step_acc;
    logic [63:0] prod;
    logic [31:0] quo, rem;

    // Signed ops run on magnitudes; signs are re-applied in FIX.
    assign a_neg = ~op[0] & a[31];
    assign b_neg = ~op[0] & b[31];
    assign a_abs = a_neg ? (32'd0 - a) : a;
    assign b_abs = b_neg ? (32'd0 - b) : b;

    assign prod = neg_q   ? (64'd0 - acc_q)        : acc_q;
    assign quo  = neg_q   ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
    assign rem  = sgn_a_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    mdu_step u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opb_i    (opb_q),
        .acc_o    (step_acc)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        sgn_a_d  = sgn_a_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_hi) hi_d = wdata;
                if (wr_lo) lo_d = wdata;
                if (start) begin
                    state_d  = CALC;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    sgn_a_d  = a_neg;
                    neg_d    = a_neg ^ b_neg;
                    dz_d     = op[1] & (b == 32'd0);
                    acc_d    = op[1] ? {32'd0, a_abs} : {32'd0, b_abs};
                    opb_d    = op[1] ? b_abs : a_abs;
                end
            end
            CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    hi_d = rem;
                    lo_d = dz_q ? MDU_DIV0_LO : quo;
                end else begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            sgn_a_q  <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            sgn_a_q  <= sgn_a_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed table, random ops vs. arithmetic model, corner sequences.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mdu_hilo dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural results straight from MIPS semantics using wide integer arithmetic.
    function automatic void model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                  output logic [31:0] mhi, output logic [31:0] mlo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(ma);
        sb = $signed(mb);
        mhi = '0;
        mlo = '0;
        case (mop)
            2'b00: begin p = sa * sb; mhi = p[63:32]; mlo = p[31:0]; end
            2'b01: begin p = {32'd0, ma} * {32'd0, mb}; mhi = p[63:32]; mlo = p[31:0]; end
            2'b10: begin
                if (mb == 0) begin mhi = ma; mlo = 32'hFFFF_FFFF; end
                else begin q = sa / sb; r = sa % sb; mhi = r[31:0]; mlo = q[31:0]; end
            end
            default: begin
                if (mb == 0) begin mhi = ma; mlo = 32'hFFFF_FFFF; end
                else begin mhi = ma % mb; mlo = ma / mb; end
            end
        endcase
    endfunction

    // Drive at a negedge; inputs are held across one rising edge then released.
    task automatic launch(input logic s, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic whi, input logic wlo, input logic [31:0] wd);
        start = s; op = o; a = x; b = y; wr_hi = whi; wr_lo = wlo; wdata = wd;
        @(posedge clk);
        #1;
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    endtask

    // Returns at the negedge where done is seen; counts busy samples before it.
    task automatic wait_done(output logic ok, output int bcnt);
        ok = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
            else if (busy) bcnt++;
        end
    endtask

    initial begin
        logic ok;
        int bc;
        logic [31:0] eh, el;
        logic [1:0] rop;
        logic [31:0] ra, rb;

        tbl[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        tbl[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        tbl[3] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[4] = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
        tbl[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        tbl[6] = '{2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
        tbl[7] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};

        #12;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            launch(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 1'b0, 32'd0);
            wait_done(ok, bc);
            check($sformatf("vec%0d done seen", i), 64'(ok), 64'd1);
            check($sformatf("vec%0d busy cycles", i), 64'(bc), 64'd33);
            check($sformatf("vec%0d hi", i), 64'(hi), 64'(tbl[i].hi));
            check($sformatf("vec%0d lo", i), 64'(lo), 64'(tbl[i].lo));
            @(negedge clk);
            check($sformatf("vec%0d done pulse", i), 64'({done, busy}), 64'd0);
        end

        // Back-to-back random ops: each new start lands on the edge right after done.
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, eh, el);
            launch(1'b1, rop, ra, rb, 1'b0, 1'b0, 32'd0);
            wait_done(ok, bc);
            check($sformatf("rand%0d op%0d %h,%h done", i, rop, ra, rb), 64'({ok, bc[7:0]}), 64'({1'b1, 8'd33}));
            check($sformatf("rand%0d op%0d %h,%h hilo", i, rop, ra, rb), {hi, lo}, {eh, el});
        end
        @(negedge clk);

        launch(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'h0000_1234);
        check("mtlo lo", 64'(lo), 64'h1234);
        check("mtlo busy", 64'(busy), 64'd0);
        @(negedge clk);

        launch(1'b1, 2'b01, 32'd2, 32'd3, 1'b1, 1'b0, 32'h0000_ABCD);
        check("mthi with start hi", 64'(hi), 64'hABCD);
        check("mthi with start lo held", 64'(lo), 64'h1234);
        wait_done(ok, bc);
        check("mthi with start result", {31'd0, ok, hi, lo}, {31'd0, 1'b1, 32'd0, 32'd6});
        @(negedge clk);

        launch(1'b1, 2'b01, 32'd5, 32'd7, 1'b0, 1'b0, 32'd0);
        repeat (5) @(negedge clk);
        launch(1'b1, 2'b11, 32'd100, 32'd3, 1'b1, 1'b1, 32'hDEAD_BEEF);
        check("busy write ignored", {hi, lo}, {32'd0, 32'd6});
        wait_done(ok, bc);
        check("busy start ignored result", {31'd0, ok, hi, lo}, {31'd0, 1'b1, 32'd0, 32'd35});
        @(negedge clk);
        check("busy start not queued", 64'(busy), 64'd0);

        launch(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 32'h0000_0055);
        check("mthi idle", 64'(hi), 64'h55);
        @(negedge clk);
        launch(1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async reset busy", 64'(busy), 64'd0);
        check("async reset hilo", {hi, lo}, 64'd0);
        check("async reset done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        launch(1'b1, 2'b01, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0);
        wait_done(ok, bc);
        check("post reset latency", 64'({ok, bc[7:0]}), 64'({1'b1, 8'd33}));
        check("post reset result", {hi, lo}, {32'd0, 32'd12});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Iterative multiply/divide unit with the architectural HI/LO register pair for the MIPS core. It sits downstream of the EX-stage 32-bit result demux, which steers operands and `mthi`/`mtlo` data here. It executes MULT, MULTU, DIV and DIVU over 33 cycles and presents HI/LO to the `mfhi`/`mflo` read path. The pipeline stalls on `busy`.

## Interface
- `ITER`, default 32: iteration count; fixed by the 32-bit operand width.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: launch the operation in `op`; sampled only in IDLE.
- `op`  in  2: operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  32: rs operand; multiplicand or dividend.
- `b`  in  32: rt operand; multiplier or divisor.
- `wr_hi`  in  1: `mthi` write strobe.
- `wr_lo`  in  1: `mtlo` write strobe.
- `wdata`  in  32: `mthi`/`mtlo` data.
- `busy`  out  1: operation in flight; the pipeline must stall `mfhi`/`mflo` and new MDU instructions.
- `done`  out  1: one-cycle pulse when HI/LO take a result.
- `hi`  out  32: HI register.
- `lo`  out  32: LO register.

## Operation
- States:
  - IDLE: waits for `start` or `mthi`/`mtlo` writes.
  - CALC: 32 iterations.
  - FIX: sign correction and HI/LO write.
- IDLE→CALC on `start`. Operands latched. For signed ops, absolute values are latched and the operand signs are recorded. Iteration counter cleared.
- CALC:
  - Multiply: shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
  - Divide: restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
  - CALC→FIX when the counter reaches `ITER`-1 at the edge.
- FIX→IDLE. HI/LO written and `done` set for exactly one cycle.
  - MULT: 64-bit product negated if the operand signs differ.
  - DIV: quotient negated if the signs differ; remainder takes the sign of the dividend.
  - Multiply results: HI = upper 32 bits, LO = lower 32 bits.
  - Divide results: HI = remainder, LO = quotient.
- Divide by zero (DIV or DIVU): HI = `a`, LO = 0xFFFFFFFF. No exception.
- DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. This falls out of the unsigned core with no special case.
- `wr_hi`/`wr_lo` write at the edge only in IDLE. Both may be asserted together.
- While busy, `wr_hi`/`wr_lo` and `start` are ignored, with no queuing.
- `start` together with `wr_hi`/`wr_lo` in IDLE: the write takes effect at that edge, and the operation result overwrites HI/LO at FIX.
- `hi`/`lo` hold their old values during CALC.

## Timing
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, state IDLE, counter 0.
- Reset mid-operation aborts immediately and asynchronously to these values. Nothing partial is written.
- `start` accepted at edge E0.
- `busy` is 1 from after E0 until E33 (33 cycles).
- E1–E32 are the iterations. E33 is FIX: `hi`/`lo` are updated and `done` is 1 for the following cycle.
- `busy` is combinational from state: high in CALC and FIX.
- A new `start` may be accepted at E34, i.e. back-to-back operations with one IDLE cycle.
- `mthi`/`mtlo` latency is one edge.

## Structure
- Package `mdu_pkg` holds:
  - op encodings (`MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`);
  - the state enum (IDLE, CALC, FIX);
  - `MDU_ITER` = 32;
  - the divide-by-zero LO constant 0xFFFFFFFF.
- One sub-module, `mdu_step`: a combinational single-iteration datapath.
  - Multiply: conditional add plus shift.
  - Divide: trial subtract, restore, and quotient-bit shift.
  - Selected by a mul/div flag.
- The FSM, counter, sign recording, FIX logic and HI/LO registers live in `mdu_hilo`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. `done` high only in the cycle after E33; `busy` high exactly 33 cycles.
- MULT 0xFFFFFFFD (−3) × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0.
- DIV 0xFFFFFFF9 (−7) / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 7 / 2 → LO = 3, HI = 1. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU 5 / 0 → HI = 5, LO = 0xFFFFFFFF. DIV 0xFFFFFFF9 / 0 → HI = 0xFFFFFFF9, LO = 0xFFFFFFFF.
- Idle-state writes and busy-time rejections, checked in sequence:
  - `wr_lo` 0x1234 in IDLE → `lo` = 0x1234 after one edge.
  - `wr_hi` 0xABCD plus `start` (MULTU 2×3) → `hi` = 0xABCD, then HI = 0, LO = 6 at done.
  - `start` and `wr_hi` during CALC → ignored; the result is unchanged.
- `rst_n` low at iteration 10 → `busy` = 0, `hi` = `lo` = 0 immediately. After release, MULTU 3×4 → LO = 12 with normal latency.
